// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// The loader turns a stream of 32-bit words into big-endian byte writes.
package imem_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int MEM_BYTES_DEF  = 1024;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2,
        ST_OVF   = 2'd3
    } state_e;

endpackage

// File: rtl/word_byte_serializer.sv
// Splits one 32-bit word into four byte beats, MSB first, one beat per cycle.
// The byte output is a register, so it holds its last value once the beats end.
module word_byte_serializer
    import imem_loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [31:0] word_i,
    output logic        we_o,
    output logic [7:0]  byte_o,
    output logic        last_beat_o
);

    logic        we_q;
    logic [7:0]  byte_q;
    logic [23:0] rest_q;
    logic [1:0]  beat_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            we_q   <= 1'b0;
            byte_q <= 8'h00;
            rest_q <= 24'h0;
            beat_q <= 2'd0;
        end else if (start_i) begin
            we_q   <= 1'b1;
            byte_q <= word_i[31:24];
            rest_q <= word_i[23:0];
            beat_q <= 2'd0;
        end else if (we_q) begin
            beat_q <= beat_q + 2'd1;
            rest_q <= {rest_q[15:0], 8'h00};
            // After the final beat the byte is held rather than shifted in as zero.
            if (beat_q == 2'(BYTES_PER_WORD - 1)) begin
                we_q <= 1'b0;
            end else begin
                byte_q <= rest_q[23:16];
            end
        end
    end

    assign we_o        = we_q;
    assign byte_o      = byte_q;
    assign last_beat_o = we_q && (beat_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Loads a program word-by-word into byte-wide instruction memory, holding the
// CPU in reset until the last word lands or the memory overflows.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEF,
    parameter int ADDR_W    = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [31:0]       in_data,
    input  logic              in_last,
    output logic              in_ready,
    input  logic              restart,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W-2:0] word_count
);

    localparam int WC_W = ADDR_W - 1;
    localparam logic [WC_W-1:0] WORDS_MAX = WC_W'(MEM_BYTES / BYTES_PER_WORD);

    state_e            state_q;
    logic [WC_W-1:0]   wc_q;
    logic [WC_W-1:0]   wc_d;
    logic [ADDR_W-1:0] addr_q;
    logic              in_ready_q;
    logic              cpu_reset_q;
    logic              done_q;
    logic              ovf_q;
    logic              last_q;
    logic              xfer;
    logic              ser_last_beat;

    // in_ready_q is only ever high in LOAD, so it alone qualifies a transfer.
    assign xfer = in_valid && in_ready_q;
    assign wc_d = wc_q + WC_W'(1);

    word_byte_serializer u_ser (
        .clk_i       (clk),
        .rst_ni      (reset),
        .start_i     (xfer),
        .word_i      (in_data),
        .we_o        (mem_we),
        .byte_o      (mem_wdata),
        .last_beat_o (ser_last_beat)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_LOAD;
            wc_q        <= '0;
            addr_q      <= '0;
            in_ready_q  <= 1'b0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            unique case (state_q)
                ST_LOAD: begin
                    in_ready_q <= 1'b1;
                    if (xfer) begin
                        state_q    <= ST_WRITE;
                        in_ready_q <= 1'b0;
                        last_q     <= in_last;
                        addr_q     <= ADDR_W'({wc_q, 2'b00});
                    end
                end
                ST_WRITE: begin
                    if (ser_last_beat) begin
                        wc_q <= wc_d;
                        // A word flagged last wins even if it exactly fills memory.
                        if (last_q) begin
                            state_q     <= ST_DONE;
                            done_q      <= 1'b1;
                            cpu_reset_q <= 1'b0;
                        end else if (wc_d == WORDS_MAX) begin
                            state_q <= ST_OVF;
                            ovf_q   <= 1'b1;
                        end else begin
                            state_q    <= ST_LOAD;
                            in_ready_q <= 1'b1;
                        end
                    end else begin
                        addr_q <= addr_q + ADDR_W'(1);
                    end
                end
                ST_DONE, ST_OVF: begin
                    if (restart) begin
                        state_q     <= ST_LOAD;
                        wc_q        <= '0;
                        in_ready_q  <= 1'b1;
                        cpu_reset_q <= 1'b1;
                        done_q      <= 1'b0;
                        ovf_q       <= 1'b0;
                    end
                end
                default: state_q <= ST_LOAD;
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign mem_addr   = addr_q;
    assign cpu_reset  = cpu_reset_q;
    assign done       = done_q;
    assign overflow   = ovf_q;
    assign word_count = wc_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a default-size instance and a 16-byte instance
// for the overflow path. Inputs change and outputs are sampled on the falling edge.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        in_valid = 1'b0, in_last = 1'b0, restart = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready, mem_we, cpu_reset, done, overflow;
    logic [9:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [8:0]  word_count;

    logic        s_in_valid = 1'b0, s_in_last = 1'b0, s_restart = 1'b0;
    logic [31:0] s_in_data = '0;
    logic        s_in_ready, s_mem_we, s_cpu_reset, s_done, s_overflow;
    logic [3:0]  s_mem_addr;
    logic [7:0]  s_mem_wdata;
    logic [2:0]  s_word_count;

    int n_pass = 0;
    int n_tot  = 0;

    always #5 clk = ~clk;

    imem_loader u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready), .restart(restart),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_reset(cpu_reset), .done(done), .overflow(overflow),
        .word_count(word_count)
    );

    imem_loader #(.MEM_BYTES(16), .ADDR_W(4)) u_small (
        .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_data(s_in_data),
        .in_last(s_in_last), .in_ready(s_in_ready), .restart(s_restart),
        .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
        .cpu_reset(s_cpu_reset), .done(s_done), .overflow(s_overflow),
        .word_count(s_word_count)
    );

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_tot++;
        if ({mem_we, mem_addr, mem_wdata, cpu_reset, done, overflow, in_ready, word_count}
            !== {1'b0, 10'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 9'd0})
            $display("FAIL reset_state: got we=%b addr=%0d wd=%0h cr=%b dn=%b ov=%b rdy=%b wc=%0d",
                     mem_we, mem_addr, mem_wdata, cpu_reset, done, overflow, in_ready, word_count);
        else n_pass++;
        reset = 1'b1;
        @(negedge clk);
        n_tot++;
        if ({in_ready, s_in_ready, cpu_reset, mem_we} !== 4'b1110)
            $display("FAIL reset_release: got rdy=%b s_rdy=%b cr=%b we=%b expected 1 1 1 0",
                     in_ready, s_in_ready, cpu_reset, mem_we);
        else n_pass++;
    endtask

    task automatic test_single();
        logic [31:0] w;
        w = 32'h2008000A;
        in_valid = 1'b1; in_data = w; in_last = 1'b1;
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            if (b == 0) in_valid = 1'b0;
            n_tot++;
            if ({mem_we, mem_addr, mem_wdata, in_ready} !== {1'b1, 10'(b), w[31-8*b -: 8], 1'b0})
                $display("FAIL single_byte%0d: got we=%b addr=%0d wd=%0h rdy=%b expected 1 %0d %0h 0",
                         b, mem_we, mem_addr, mem_wdata, in_ready, b, w[31-8*b -: 8]);
            else n_pass++;
        end
        @(negedge clk);
        n_tot++;
        if ({mem_we, done, cpu_reset, overflow, in_ready, word_count, mem_addr, mem_wdata}
            !== {5'b01000, 9'd1, 10'd3, 8'h0A})
            $display("FAIL single_done: got we=%b dn=%b cr=%b ov=%b rdy=%b wc=%0d addr=%0d wd=%0h",
                     mem_we, done, cpu_reset, overflow, in_ready, word_count, mem_addr, mem_wdata);
        else n_pass++;
    endtask

    task automatic restart_pulse(input string tag);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        n_tot++;
        if ({in_ready, cpu_reset, done, overflow, word_count} !== {4'b1100, 9'd0})
            $display("FAIL %s_restart: got rdy=%b cr=%b dn=%b ov=%b wc=%0d expected 1 1 0 0 0",
                     tag, in_ready, cpu_reset, done, overflow, word_count);
        else n_pass++;
    endtask

    task automatic test_restart();
        logic [31:0] w;
        w = 32'hFFFFFFFF;
        restart_pulse("rst_new");
        in_valid = 1'b1; in_data = w; in_last = 1'b1;
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            if (b == 0) begin in_valid = 1'b0; restart = 1'b1; end
            if (b == 1) restart = 1'b0;
            n_tot++;
            if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 10'(b), 8'hFF})
                $display("FAIL restart_byte%0d: got we=%b addr=%0d wd=%0h expected 1 %0d ff",
                         b, mem_we, mem_addr, mem_wdata, b);
            else n_pass++;
        end
        @(negedge clk);
        n_tot++;
        if ({mem_we, done, cpu_reset, word_count} !== {3'b010, 9'd1})
            $display("FAIL restart_done: got we=%b dn=%b cr=%b wc=%0d expected 0 1 0 1",
                     mem_we, done, cpu_reset, word_count);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] ws [3];
        ws[0] = 32'h12345678; ws[1] = 32'h9ABCDEF0; ws[2] = 32'h0BADF00D;
        restart_pulse("b2b");
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_tot++;
            if (in_ready !== 1'b1)
                $display("FAIL b2b_ready%0d: got %b expected 1", i, in_ready);
            else n_pass++;
            in_data = ws[i]; in_last = (i == 2);
            for (int b = 0; b < 4; b++) begin
                @(negedge clk);
                n_tot++;
                if ({mem_we, mem_addr, mem_wdata, in_ready}
                    !== {1'b1, 10'(4*i+b), ws[i][31-8*b -: 8], 1'b0})
                    $display("FAIL b2b_w%0d_b%0d: got we=%b addr=%0d wd=%0h rdy=%b expected 1 %0d %0h 0",
                             i, b, mem_we, mem_addr, mem_wdata, in_ready, 4*i+b, ws[i][31-8*b -: 8]);
                else n_pass++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0; in_last = 1'b0;
        n_tot++;
        if ({mem_we, done, cpu_reset, word_count} !== {3'b010, 9'd3})
            $display("FAIL b2b_done: got we=%b dn=%b cr=%b wc=%0d expected 0 1 0 3",
                     mem_we, done, cpu_reset, word_count);
        else n_pass++;
    endtask

    task automatic test_overflow();
        logic [31:0] ws [5];
        ws[0] = 32'h11223344; ws[1] = 32'h55667788; ws[2] = 32'h99AABBCC;
        ws[3] = 32'hDDEEFF00; ws[4] = 32'hCAFEBABE;
        s_in_valid = 1'b1; s_in_last = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_tot++;
            if (s_in_ready !== 1'b1)
                $display("FAIL ovf_ready%0d: got %b expected 1", i, s_in_ready);
            else n_pass++;
            s_in_data = ws[i];
            for (int b = 0; b < 4; b++) begin
                @(negedge clk);
                n_tot++;
                if ({s_mem_we, s_mem_addr, s_mem_wdata} !== {1'b1, 4'(4*i+b), ws[i][31-8*b -: 8]})
                    $display("FAIL ovf_w%0d_b%0d: got we=%b addr=%0d wd=%0h expected 1 %0d %0h",
                             i, b, s_mem_we, s_mem_addr, s_mem_wdata, 4*i+b, ws[i][31-8*b -: 8]);
                else n_pass++;
            end
            @(negedge clk);
        end
        s_in_data = ws[4];
        n_tot++;
        if ({s_overflow, s_cpu_reset, s_done, s_in_ready, s_mem_we, s_word_count} !== {5'b11000, 3'd4})
            $display("FAIL ovf_state: got ov=%b cr=%b dn=%b rdy=%b we=%b wc=%0d expected 1 1 0 0 0 4",
                     s_overflow, s_cpu_reset, s_done, s_in_ready, s_mem_we, s_word_count);
        else n_pass++;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_tot++;
            if ({s_mem_we, s_in_ready, s_overflow, s_mem_addr} !== {3'b001, 4'd15})
                $display("FAIL ovf_hold%0d: got we=%b rdy=%b ov=%b addr=%0d expected 0 0 1 15",
                         c, s_mem_we, s_in_ready, s_overflow, s_mem_addr);
            else n_pass++;
        end
        s_in_valid = 1'b0;
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] w;
        w = 32'hA5C35A96;
        restart_pulse("mid");
        in_valid = 1'b1; in_data = 32'h01020304; in_last = 1'b0;
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            if (b == 0) in_valid = 1'b0;
        end
        @(negedge clk);
        n_tot++;
        if ({in_ready, word_count} !== {1'b1, 9'd1})
            $display("FAIL mid_first_word: got rdy=%b wc=%0d expected 1 1", in_ready, word_count);
        else n_pass++;
        in_valid = 1'b1; in_data = w;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        n_tot++;
        if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 10'd5, 8'hC3})
            $display("FAIL mid_byte1: got we=%b addr=%0d wd=%0h expected 1 5 c3", mem_we, mem_addr, mem_wdata);
        else n_pass++;
        reset = 1'b0;
        #1;
        n_tot++;
        if ({mem_we, word_count, in_ready, cpu_reset, mem_addr} !== {1'b0, 9'd0, 2'b01, 10'd0})
            $display("FAIL mid_reset: got we=%b wc=%0d rdy=%b cr=%b addr=%0d expected 0 0 0 1 0",
                     mem_we, word_count, in_ready, cpu_reset, mem_addr);
        else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_tot++;
        if ({in_ready, mem_we, word_count} !== {2'b10, 9'd0})
            $display("FAIL mid_release: got rdy=%b we=%b wc=%0d expected 1 0 0", in_ready, mem_we, word_count);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_restart();
        test_back_to_back();
        test_overflow();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 1024, meaning instruction-memory size in bytes (multiple of 4).
REQ-002 SHALL have parameter ADDR_W, default 10, meaning byte-address width with 2**ADDR_W >= MEM_BYTES.
REQ-003 SHALL have port clk, input, 1, system clock; one clock domain; all state on rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset (loader clears while reset=0).
REQ-005 SHALL have port in_valid, input, 1, upstream holds a valid instruction word.
REQ-006 SHALL have port in_data, input, 32, instruction word, MSB = first byte in memory.
REQ-007 SHALL have port in_last, input, 1, qualifies in_data as final word of program.
REQ-008 SHALL have port in_ready, output, 1, loader accepts a word this cycle.
REQ-009 SHALL have port restart, input, 1, single-cycle request to begin a new load.
REQ-010 SHALL have port mem_we, output, 1, byte write strobe to instruction memory.
REQ-011 SHALL have port mem_addr, output, ADDR_W, byte address of write.
REQ-012 SHALL have port mem_wdata, output, 8, byte written.
REQ-013 SHALL have port cpu_reset, output, 1, active-high hold of the CPU core while the program is incomplete.
REQ-014 SHALL have port done, output, 1, program loaded, CPU released.
REQ-015 SHALL have port overflow, output, 1, program exceeded MEM_BYTES; load aborted.
REQ-016 SHALL have port word_count, output, ADDR_W-1, number of words fully written this load.

Function
REQ-017 SHALL implement FSM states LOAD, WRITE, DONE, OVF; all outputs registered.
REQ-018 In LOAD, in_ready SHALL be 1; transfer occurs when in_valid=1 and in_ready=1 on a clock edge.
REQ-019 On a transfer, the loader SHALL latch in_data and in_last, go to WRITE, and drop in_ready the next cycle.
REQ-020 In WRITE, the loader SHALL issue four consecutive mem_we=1 cycles with addresses 4*word_count+0..+3 and data in_data[31:24], [23:16], [15:8], [7:0] in that order.
REQ-021 Latency SHALL be: transfer at edge N gives byte writes in cycles N+1..N+4, with in_ready=1 again in cycle N+5 (LOAD) if not last; throughput is 1 word per 5 cycles.
REQ-022 After the 4th byte, word_count SHALL increment by 1; if the latched last=1 the next state SHALL be DONE.
REQ-023 If last=0 and word_count reaches MEM_BYTES/4 after the increment, the next state SHALL be OVF; no write is issued beyond address MEM_BYTES-1.
REQ-024 cpu_reset SHALL be 1 in LOAD, WRITE and OVF, and 0 only in DONE; done=1 only in DONE; overflow=1 only in OVF.
REQ-025 mem_we SHALL be 0 outside WRITE; mem_addr and mem_wdata hold their last values when mem_we=0.
REQ-026 restart=1 in DONE or OVF SHALL return to LOAD with word_count=0 and cpu_reset=1 the next cycle; restart in LOAD or WRITE SHALL be ignored.
REQ-027 in_valid in WRITE/DONE/OVF SHALL cause no transfer; upstream holds the word until in_ready=1.

Reset
REQ-028 While reset=0, the loader SHALL asynchronously force state=LOAD, word_count=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_reset=1, done=0, overflow=0, in_ready=0.
REQ-029 in_ready SHALL rise in the first cycle after reset deasserts; reset during WRITE SHALL abort the word with no further mem_we.

Structure
REQ-030 Package imem_loader_pkg SHALL hold the state enum, BYTES_PER_WORD=4 and the MEM_BYTES default.
REQ-031 The byte sequencing SHALL be a sub-module word_byte_serializer (32-bit in, 4 byte beats out, 2-bit beat counter); FSM and counters stay in imem_loader.

Verification
REQ-032 The bench SHALL cover: single word 0x2008000A with last=1 -> writes 0x20,0x08,0x00,0x0A at addr 0..3 in cycles N+1..N+4, then done=1, cpu_reset=0, word_count=1.
REQ-033 The bench SHALL cover: 3 words back-to-back with in_valid held high -> transfers 5 cycles apart, addr 0..11 written in big-endian byte order, word_count=3.
REQ-034 The bench SHALL cover: MEM_BYTES=16 with 5 words, none marked last -> 4 words written to addr 0..15, overflow=1, cpu_reset=1, 5th word never accepted.
REQ-035 The bench SHALL cover: reset=0 after the 2nd byte write -> mem_we=0 immediately, word_count=0, in_ready=1 the cycle after release.
REQ-036 The bench SHALL cover: restart pulse in DONE, then a new word 0xFFFFFFFF with last=1 -> writes at addr 0..3, done=1 again; a restart pulse during WRITE has no effect.
